// File: rtl/si_put.sv
// si_put: buffers one PSI/SI section received as a byte burst, validates it,
// and transmits it as 188-byte MPEG-TS packets on a configured PID. The stored
// section can be re-sent on request for periodic table repetition.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   pid           PID for output packets, sampled on the first byte of a burst
//   sec_din       section bytes, table_id first
//   sec_din_en    byte valid; one contiguous burst per section
//   send_req      one-cycle pulse: re-send the stored section
//   ts_dout       TS byte stream (0 when not valid)
//   ts_dout_en    byte valid, 188 consecutive cycles per packet
//   ts_dout_sop   marks the 0x47 sync byte
//   busy          packet transmission in progress
//   sec_err       one-cycle pulse when a burst is rejected
module si_put #(
  parameter int unsigned MAX_LEN    = 4096,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] pid,
  input  logic [7:0]  sec_din,
  input  logic        sec_din_en,
  input  logic        send_req,
  output logic [7:0]  ts_dout,
  output logic        ts_dout_en,
  output logic        ts_dout_sop,
  output logic        busy,
  output logic        sec_err
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [12:0]   MaxLen  = 13'(MAX_LEN);
  localparam logic [GW-1:0] GapLast = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StHdr, StPtr, StData, StStuff, StGap} state_e;

  // Write side
  logic        en_q, ign_q, ovf_q;
  logic [12:0] wr_cnt_q, pid_lat_q, pid_q, sec_len_q;
  logic [3:0]  b1_q;
  logic [7:0]  b2_q;
  logic        valid_q, pending_q, sec_err_q;

  logic        burst_start, burst_end, ign_now, wr_ok, sec_good, accept, start_pkt;
  logic [12:0] cnt_base;

  logic [7:0]  mem [MAX_LEN];
  logic [7:0]  ram_q;

  // Packet side
  state_e      state_q, state_d;
  logic [7:0]  pos_q, pos_d;
  logic [12:0] rd_addr_q, rd_addr_d;
  logic        first_q, first_d;
  logic [3:0]  cc_q, cc_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]  dout_d;
  logic        den_d, sop_d;
  logic [7:0]  dout_q;
  logic        den_q, sop_q;

  assign busy        = (state_q != StIdle);
  assign burst_start = sec_din_en & ~en_q;
  assign burst_end   = ~sec_din_en & en_q;
  // A burst that starts during transmission is dropped for its whole length.
  assign ign_now     = burst_start ? busy : ign_q;
  assign cnt_base    = burst_start ? 13'd0 : wr_cnt_q;
  assign wr_ok       = sec_din_en & ~ign_now & (cnt_base < MaxLen);
  assign sec_good    = ~ovf_q & (wr_cnt_q >= 13'd3) &
                       (wr_cnt_q == ({1'b0, b1_q, b2_q} + 13'd3));
  assign accept      = burst_end & ~ign_q & sec_good;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      ign_q     <= 1'b0;
      ovf_q     <= 1'b0;
      wr_cnt_q  <= '0;
      b1_q      <= '0;
      b2_q      <= '0;
      pid_lat_q <= '0;
      pid_q     <= '0;
      sec_len_q <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      sec_err_q <= 1'b0;
    end else begin
      en_q      <= sec_din_en;
      sec_err_q <= 1'b0;
      if (sec_din_en) begin
        ign_q <= ign_now;
        ovf_q <= (burst_start ? 1'b0 : ovf_q) | (cnt_base >= MaxLen);
        if (cnt_base != '1) wr_cnt_q <= cnt_base + 13'd1;
        if (cnt_base == 13'd1) b1_q <= sec_din[3:0];
        if (cnt_base == 13'd2) b2_q <= sec_din;
        if (burst_start) pid_lat_q <= pid;
      end
      if (burst_end) begin
        if (ign_q) begin
          sec_err_q <= 1'b1;
        end else if (sec_good) begin
          sec_len_q <= wr_cnt_q;
          pid_q     <= pid_lat_q;
          valid_q   <= 1'b1;
        end else begin
          sec_err_q <= 1'b1;
          valid_q   <= 1'b0;
        end
      end
      // One-deep request: later sets win over the clear at packet start.
      if (start_pkt) pending_q <= 1'b0;
      if (send_req && valid_q) pending_q <= 1'b1;
      if (accept) pending_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[cnt_base[AW-1:0]] <= sec_din;
  end

  // Read with the next address so ram_q always holds mem[rd_addr_q]; DATA
  // bytes then stream without bubbles.
  always_ff @(posedge clk) begin
    ram_q <= mem[rd_addr_d[AW-1:0]];
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    rd_addr_d = rd_addr_q;
    first_d   = first_q;
    cc_d      = cc_q;
    gap_d     = gap_q;
    dout_d    = 8'h00;
    den_d     = 1'b0;
    sop_d     = 1'b0;
    start_pkt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          start_pkt = 1'b1;
          state_d   = StHdr;
          pos_d     = 8'd0;
          rd_addr_d = 13'd0;
          first_d   = 1'b1;
        end
      end
      StHdr: begin
        den_d = 1'b1;
        pos_d = pos_q + 8'd1;
        case (pos_q[1:0])
          2'd0:    begin dout_d = 8'h47; sop_d = 1'b1; end
          2'd1:    dout_d = {1'b0, first_q, 1'b0, pid_q[12:8]};
          2'd2:    dout_d = pid_q[7:0];
          default: begin
            dout_d  = {4'b0001, cc_q};
            state_d = first_q ? StPtr : StData;
          end
        endcase
      end
      StPtr: begin
        den_d   = 1'b1;
        pos_d   = pos_q + 8'd1;
        state_d = StData;
      end
      StData: begin
        den_d     = 1'b1;
        dout_d    = ram_q;
        pos_d     = pos_q + 8'd1;
        rd_addr_d = rd_addr_q + 13'd1;
        if (pos_q == 8'd187) begin
          state_d = StGap;
        end else if (rd_addr_d == sec_len_q) begin
          state_d = StStuff;
        end
      end
      StStuff: begin
        den_d  = 1'b1;
        dout_d = 8'hFF;
        pos_d  = pos_q + 8'd1;
        if (pos_q == 8'd187) state_d = StGap;
      end
      StGap: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GapLast) begin
          gap_d   = '0;
          pos_d   = 8'd0;
          state_d = (rd_addr_q < sec_len_q) ? StHdr : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Packet closes on its last byte.
    if (den_d && pos_q == 8'd187) begin
      cc_d    = cc_q + 4'd1;
      first_d = 1'b0;
      gap_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pos_q     <= '0;
      rd_addr_q <= '0;
      first_q   <= 1'b0;
      cc_q      <= '0;
      gap_q     <= '0;
      dout_q    <= '0;
      den_q     <= 1'b0;
      sop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      rd_addr_q <= rd_addr_d;
      first_q   <= first_d;
      cc_q      <= cc_d;
      gap_q     <= gap_d;
      dout_q    <= dout_d;
      den_q     <= den_d;
      sop_q     <= sop_d;
    end
  end

  assign ts_dout     = dout_q;
  assign ts_dout_en  = den_q;
  assign ts_dout_sop = sop_q;
  assign sec_err     = sec_err_q;

endmodule

// File: tb/tb_si_put.sv
// tb_si_put: directed sequence with randomized section contents and PIDs,
// checked against a packetization model computed from section length rules.
module tb_si_put;
  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] pid;
  logic [7:0]  sec_din;
  logic        sec_din_en;
  logic        send_req;
  logic [7:0]  ts_dout;
  logic        ts_dout_en;
  logic        ts_dout_sop;
  logic        busy;
  logic        sec_err;

  always #5 clk = ~clk;

  si_put #(.MAX_LEN(4096), .GAP_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .pid(pid), .sec_din(sec_din), .sec_din_en(sec_din_en),
    .send_req(send_req), .ts_dout(ts_dout), .ts_dout_en(ts_dout_en),
    .ts_dout_sop(ts_dout_sop), .busy(busy), .sec_err(sec_err)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  // Observation state filled by the monitor
  logic [7:0]  cap[$];
  int unsigned sop_cyc[$];
  int run = 0, idle = 1000, viol = 0, err_cnt = 0;

  // Model state
  logic [7:0]  tx_q[$], mdl_sec[$], exp_q[$];
  logic [12:0] mdl_pid = '0;
  logic [3:0]  mdl_cc = '0;
  int unsigned lo_cyc = 0;
  int err0 = 0, viol0 = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: collects bytes, flags framing violations (length, sop, gap, idle data).
  initial forever begin
    @(negedge clk);
    if (sec_err) err_cnt++;
    if (rst) begin
      run = 0;
      idle = 1000;
    end else if (ts_dout_en) begin
      if (run == 0 && idle < 8) viol++;
      if (ts_dout_sop !== (run == 0)) viol++;
      if (run == 0) sop_cyc.push_back(cyc);
      cap.push_back(ts_dout);
      run++;
      idle = 0;
    end else begin
      if (run != 0 && run != 188) viol++;
      if (ts_dout !== 8'h00 || ts_dout_sop !== 1'b0) viol++;
      run = 0;
      if (idle < 1000) idle++;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected TS bytes for one transmission of the stored section.
  task automatic model_tx();
    int len = mdl_sec.size();
    int off = 0;
    int n;
    n = (len <= 183) ? 1 : 1 + (len - 183 + 183) / 184;
    for (int k = 0; k < n; k++) begin
      int room = (k == 0) ? 183 : 184;
      int take;
      exp_q.push_back(8'h47);
      exp_q.push_back({1'b0, (k == 0), 1'b0, mdl_pid[12:8]});
      exp_q.push_back(mdl_pid[7:0]);
      exp_q.push_back({4'h1, mdl_cc});
      mdl_cc = mdl_cc + 4'd1;
      if (k == 0) exp_q.push_back(8'h00);
      take = (len - off < room) ? len - off : room;
      for (int i = 0; i < take; i++) exp_q.push_back(mdl_sec[off + i]);
      off += take;
      for (int i = 0; i < room - take; i++) exp_q.push_back(8'hFF);
    end
  endtask

  task automatic make_section(input int len, input int fld);
    logic [11:0] f;
    f = fld[11:0];
    tx_q.delete();
    for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
    if (len >= 3) begin
      tx_q[1] = {4'($urandom), f[11:8]};
      tx_q[2] = f[7:0];
    end
  endtask

  task automatic drive_burst(input logic [12:0] p);
    @(posedge clk); #1;
    pid = p;
    for (int i = 0; i < tx_q.size(); i++) begin
      sec_din = tx_q[i];
      sec_din_en = 1'b1;
      @(posedge clk); #1;
      pid = 13'($urandom);
    end
    sec_din_en = 1'b0;
    sec_din = 8'h00;
    lo_cyc = cyc;
  endtask

  task automatic pulse_send();
    @(posedge clk); #1;
    send_req = 1'b1;
    lo_cyc = cyc;
    @(posedge clk); #1;
    send_req = 1'b0;
  endtask

  task automatic start_obs();
    cap.delete();
    sop_cyc.delete();
    exp_q.delete();
    err0 = err_cnt;
    viol0 = viol;
  endtask

  task automatic wait_idle();
    int n = 0;
    int low = 0;
    while (low < 16 && n < 30000) begin
      @(posedge clk);
      n++;
      if (busy) low = 0;
      else low++;
    end
    chk("idle_reached", (low >= 16), 1);
  endtask

  task automatic finish_obs(input string tag, input bit lat, input int errs);
    int mm = 0;
    wait_idle();
    chk({tag, "_len"}, cap.size(), exp_q.size());
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) mm++;
    chk({tag, "_byte_mismatches"}, mm, 0);
    chk({tag, "_framing_violations"}, viol - viol0, 0);
    chk({tag, "_sec_err_pulses"}, err_cnt - err0, errs);
    if (lat && sop_cyc.size() > 0) chk({tag, "_latency"}, sop_cyc[0] - lo_cyc, 3);
  endtask

  task automatic good_section(input string tag, input int len, input logic [12:0] p);
    make_section(len, len - 3);
    start_obs();
    drive_burst(p);
    mdl_sec = tx_q;
    mdl_pid = p;
    model_tx();
    finish_obs(tag, 1'b1, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    pid = '0;
    sec_din = '0;
    sec_din_en = 1'b0;
    send_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ts_dout_en", ts_dout_en, 0);
    chk("reset_ts_dout", ts_dout, 0);
    chk("reset_sop", ts_dout_sop, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sec_err", sec_err, 0);

    // Nothing stored yet: request ignored
    start_obs();
    pulse_send();
    finish_obs("send_no_section", 1'b0, 0);

    // 16-byte section 00 B0 0D ..., pid 0
    make_section(16, 13);
    tx_q[0] = 8'h00;
    tx_q[1] = 8'hB0;
    start_obs();
    drive_burst(13'h000);
    mdl_sec = tx_q;
    mdl_pid = 13'h000;
    model_tx();
    finish_obs("sec16", 1'b1, 0);

    good_section("sec400", 400, 13'h011);
    good_section("sec183", 183, 13'($urandom));
    good_section("sec367", 367, 13'($urandom));
    good_section("sec_rand_a", int'($urandom_range(3, 900)), 13'($urandom));
    good_section("sec_rand_b", int'($urandom_range(3, 900)), 13'($urandom));
    good_section("sec4096", 4096, 13'($urandom));

    // Length field inconsistent with burst length, then resend attempt
    make_section(20, 13);
    start_obs();
    drive_burst(13'h0AA);
    finish_obs("bad_len", 1'b0, 1);
    start_obs();
    pulse_send();
    finish_obs("bad_len_resend", 1'b0, 0);

    // Too short, and one byte past the buffer
    make_section(2, 0);
    start_obs();
    drive_burst(13'h001);
    finish_obs("short2", 1'b0, 1);
    make_section(4097, 4094);
    start_obs();
    drive_burst(13'h002);
    finish_obs("overflow", 1'b0, 1);

    // Periodic repetition with cc wrap
    good_section("rep_base", 10, 13'($urandom));
    for (int r = 0; r < 20; r++) begin
      start_obs();
      pulse_send();
      model_tx();
      finish_obs($sformatf("rep%0d", r), 1'b1, 0);
    end

    // Two requests while busy collapse into one extra transmission
    start_obs();
    pulse_send();
    model_tx();
    repeat (20) @(posedge clk);
    pulse_send();
    repeat (5) @(posedge clk);
    pulse_send();
    model_tx();
    finish_obs("double_req", 1'b0, 0);

    // Burst arriving mid-transmission is dropped
    start_obs();
    pulse_send();
    model_tx();
    repeat (20) @(posedge clk);
    chk("busy_before_intruder", busy, 1);
    make_section(10, 7);
    drive_burst(13'h1FF);
    pulse_send();
    model_tx();
    finish_obs("intruder", 1'b0, 1);

    // Reset in the middle of DATA
    good_section("pre_rst", 300, 13'($urandom));
    start_obs();
    pulse_send();
    n = 0;
    while (cap.size() < 30 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("reached_data", (cap.size() >= 30), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_en_low", ts_dout_en, 0);
    chk("rst_mid_busy_low", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_cc = 4'd0;
    start_obs();
    pulse_send();
    finish_obs("post_rst_send", 1'b0, 0);
    good_section("post_rst_sec", 200, 13'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
